// File: rtl/lsu_subword.sv
// Load/store unit in front of a word-addressed data memory without byte enables.
// Sub-word loads are extended here; SB/SH become a read-modify-write of the full word.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with a
// misaligned pulse instead of silently aligning the address.
module lsu_subword #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] store_data_q;

  logic        legal_load;
  logic        legal_store;
  logic [31:0] addr_accept;
  logic        in_range;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Request decode, evaluated on the live inputs at acceptance.
  always_comb begin
    legal_load  = is_load && !is_store &&
                  (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                   funct3 == 3'b100 || funct3 == 3'b101);
    legal_store = is_store && !is_load &&
                  (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_req;
  logic misaligned_q;

  assign misalign_req = (funct3[1:0] == 2'b01 && addr[0]) ||
                        (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign addr_accept  = addr;
  assign misaligned   = misaligned_q;
`else
  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    addr_accept = addr;
    case (funct3[1:0])
      2'b01:   addr_accept[0]   = 1'b0;
      2'b10:   addr_accept[1:0] = 2'b00;
      default: ;
    endcase
  end
  assign misaligned = 1'b0;
`endif

  assign in_range    = addr_q[31:2] < DEPTH_IDX;
  assign mem_address = {2'b00, addr_q[31:2]};
  assign req_ready   = (state == S_IDLE);

  // Strobes decode straight from state so rst can kill them in the same cycle.
  assign mem_read  = !rst && in_range && (state == S_LOAD || state == S_READ);
  assign mem_write = !rst && in_range && (state == S_WRITE);

  always_comb begin
    lane_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'h0, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_ext = {16'h0, lane_half};
      default: load_ext = mem_read_data;
    endcase
  end

  // Old word with the addressed byte or halfword lane replaced.
  always_comb begin
    merged = mem_read_data;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = store_data_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = store_data_q[15:0];
    end else begin
      merged[15:0] = store_data_q[15:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      funct3_q       <= '0;
      store_data_q   <= '0;
      load_data      <= '0;
      mem_write_data <= '0;
      done           <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q       <= addr_accept;
            funct3_q     <= funct3;
            store_data_q <= store_data;
            if (!(legal_load || legal_store)) begin
              state <= S_DONE;
              done  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            end else if (misalign_req) begin
              state        <= S_DONE;
              done         <= 1'b1;
              misaligned_q <= 1'b1;
`endif
            end else if (legal_load) begin
              state <= S_LOAD;
            end else if (funct3[1:0] == 2'b10) begin
              state          <= S_WRITE;
              mem_write_data <= store_data;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_LOAD: begin
          load_data <= in_range ? load_ext : '0;
          state     <= S_DONE;
          done      <= 1'b1;
        end
        S_READ: begin
          mem_write_data <= merged;
          state          <= S_WRITE;
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed self-checking bench for lsu_subword with a 32-word behavioural memory.
// Expected values are hand-computed; LSU_MISALIGN_TRAP_EN selects the misaligned-LW outcome.
module tb_lsu_subword;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        done;
  logic        misaligned;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [32];
  logic        pre_en;
  logic [4:0]  pre_idx;
  logic [31:0] pre_val;

  int n_checks = 0;
  int n_errors = 0;

  lsu_subword #(.DEPTH_WORDS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .is_load        (is_load),
    .is_store       (is_store),
    .funct3         (funct3),
    .addr           (addr),
    .store_data     (store_data),
    .load_data      (load_data),
    .done           (done),
    .misaligned     (misaligned),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads return a non-zero pattern so a forced-zero load is visible.
  assign mem_read_data = (mem_address < 32) ? mem[mem_address[4:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_write && mem_address < 32) mem[mem_address[4:0]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Issue one request and log strobes per cycle after acceptance (bit k = cycle T+k).
  task automatic run_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output int done_k, output logic [7:0] rd_mask,
                         output logic [7:0] wr_mask, output logic [31:0] wdata,
                         output logic mis);
    @(negedge clk);
    check("ready_before", req_ready, 1'b1);
    is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    done_k = 0; rd_mask = '0; wr_mask = '0; wdata = '0; mis = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      rd_mask[k] = mem_read;
      wr_mask[k] = mem_write;
      if (mem_write) wdata = mem_write_data;
      if (k == 1) check("busy_ready", req_ready, 1'b0);
      if (done) begin
        done_k = k;
        mis    = misaligned;
        break;
      end
    end
    @(negedge clk);
    check("ready_after", req_ready, 1'b1);
  endtask

  int          dk;
  logic [7:0]  rm, wm;
  logic [31:0] wd;
  logic        ms;

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = '0; addr = '0; store_data = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_misaligned", misaligned, 1'b0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);

    preload(5'd3, 32'h8081_F2A4);
    preload(5'd2, 32'h1122_3344);
    preload(5'd1, 32'h7654_3210);

    // LB / LBU on the top byte of word 3.
    run_req(1, 0, 3'b000, 32'h0F, 32'h0, dk, rm, wm, wd, ms);
    check("lb_done_k", dk, 2);
    check("lb_rd_mask", rm, 8'h02);
    check("lb_wr_mask", wm, 8'h00);
    check("lb_data", load_data, 32'hFFFF_FF80);
    check("lb_mis", ms, 1'b0);
    run_req(1, 0, 3'b100, 32'h0F, 32'h0, dk, rm, wm, wd, ms);
    check("lbu_data", load_data, 32'h0000_0080);

    // SB into byte lane 1 of word 2.
    run_req(0, 1, 3'b000, 32'h09, 32'hFFFF_FFAB, dk, rm, wm, wd, ms);
    check("sb_done_k", dk, 3);
    check("sb_rd_mask", rm, 8'h02);
    check("sb_wr_mask", wm, 8'h04);
    check("sb_wdata", wd, 32'h1122_AB44);
    check("sb_mem2", mem[2], 32'h1122_AB44);

    // SH into upper halfword, then read it back signed and unsigned.
    preload(5'd2, 32'h1122_3344);
    run_req(0, 1, 3'b001, 32'h0A, 32'h1234_BEEF, dk, rm, wm, wd, ms);
    check("sh_done_k", dk, 3);
    check("sh_wdata", wd, 32'hBEEF_3344);
    check("sh_mem2", mem[2], 32'hBEEF_3344);
    run_req(1, 0, 3'b001, 32'h0A, 32'h0, dk, rm, wm, wd, ms);
    check("lh_data", load_data, 32'hFFFF_BEEF);
    run_req(1, 0, 3'b101, 32'h0A, 32'h0, dk, rm, wm, wd, ms);
    check("lhu_data", load_data, 32'h0000_BEEF);

    // Misaligned LW.
    run_req(1, 0, 3'b010, 32'h06, 32'h0, dk, rm, wm, wd, ms);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_done_k", dk, 1);
    check("lw_mis_flag", ms, 1'b1);
    check("lw_mis_rd_mask", rm, 8'h00);
    check("lw_mis_data", load_data, 32'h0000_BEEF);
`else
    check("lw_mis_done_k", dk, 2);
    check("lw_mis_flag", ms, 1'b0);
    check("lw_mis_rd_mask", rm, 8'h02);
    check("lw_mis_data", load_data, 32'h7654_3210);
`endif

    // Aligned SW writes the whole word in one cycle.
    run_req(0, 1, 3'b010, 32'h04, 32'h0BAD_F00D, dk, rm, wm, wd, ms);
    check("sw_done_k", dk, 2);
    check("sw_wr_mask", wm, 8'h02);
    check("sw_mem1", mem[1], 32'h0BAD_F00D);

    // Word index 32 is out of range: no strobes, load returns 0.
    run_req(0, 1, 3'b010, 32'h80, 32'h5555_AAAA, dk, rm, wm, wd, ms);
    check("oor_sw_done_k", dk, 2);
    check("oor_sw_wr_mask", wm, 8'h00);
    check("oor_sw_mem0", mem[0], 32'h0);
    run_req(1, 0, 3'b010, 32'h80, 32'h0, dk, rm, wm, wd, ms);
    check("oor_lw_done_k", dk, 2);
    check("oor_lw_rd_mask", rm, 8'h00);
    check("oor_lw_data", load_data, 32'h0);

    // Illegal requests finish in one cycle and leave load_data alone.
    run_req(1, 0, 3'b010, 32'h0C, 32'h0, dk, rm, wm, wd, ms);
    check("lw_data", load_data, 32'h8081_F2A4);
    run_req(1, 1, 3'b010, 32'h08, 32'h0, dk, rm, wm, wd, ms);
    check("both_done_k", dk, 1);
    check("both_strobes", {rm, wm}, 16'h0);
    check("both_data", load_data, 32'h8081_F2A4);
    run_req(1, 0, 3'b011, 32'h08, 32'h0, dk, rm, wm, wd, ms);
    check("f3_011_done_k", dk, 1);
    check("f3_011_rd_mask", rm, 8'h00);
    run_req(0, 0, 3'b010, 32'h08, 32'h0, dk, rm, wm, wd, ms);
    check("neither_done_k", dk, 1);

    // Reset during the WRITE cycle of an SB.
    @(negedge clk);
    is_load = 1'b0; is_store = 1'b1; funct3 = 3'b000; addr = 32'h0C;
    store_data = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; is_store = 1'b0;
    @(negedge clk);
    check("rmw_rst_read", mem_read, 1'b1);
    @(negedge clk);
    check("rmw_rst_write_pre", mem_write, 1'b1);
    rst = 1'b1;
    #1;
    check("rmw_rst_write_kill", mem_write, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmw_rst_ready", req_ready, 1'b1);
    check("rmw_rst_done", done, 1'b0);
    check("rmw_rst_load_data", load_data, 32'h0);
    check("rmw_rst_mem_address", mem_address, 32'h0);
    check("rmw_rst_mem_wdata", mem_write_data, 32'h0);
    check("rmw_rst_strobes", {mem_read, mem_write}, 2'b00);
    check("rmw_rst_mem3", mem[3], 32'h8081_F2A4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit sitting directly upstream of the single-cycle core's word-addressed data memory. It accepts one load or store request from the execute stage, converts the byte address to a word index, and extends sub-word loads. Because the memory has no byte enables, it performs byte/halfword stores as a read-modify-write sequence. A ready/done handshake stalls the core while the access is in flight.

## Interface
- DEPTH_WORDS, 32, number of 32-bit words in the data memory; word indices >= DEPTH_WORDS are out of range
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present (sampled only when req_ready=1)
- req_ready  output  1  high only in IDLE
- is_load  input  1  request is a load
- is_store  input  1  request is a store
- funct3  input  3  RV32I width/sign code
- addr  input  32  byte address (ALU result)
- store_data  input  32  rs2 value; low byte/halfword used for SB/SH
- load_data  output  32  extended load result, valid while done=1, held afterwards
- done  output  1  one-cycle completion pulse
- misaligned  output  1  one-cycle pulse with done when access was rejected (macro-dependent)
- mem_address  output  32  word index {2'b00, addr[31:2]}
- mem_read  output  1  read strobe to data memory
- mem_write  output  1  write strobe to data memory
- mem_write_data  output  32  full word to write
- mem_read_data  input  32  combinational read data from memory

## Operation
- States: IDLE, LOAD, READ (RMW read), WRITE, DONE.
- IDLE: req_valid=1 registers addr, funct3, store_data, is_load, is_store, then moves to:
  - LOAD: is_load, !is_store
  - WRITE: SW
  - READ: SB/SH
  - DONE: illegal request (both is_load and is_store, neither, or an undefined funct3). No memory strobe; load_data is unchanged.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- LOAD:
  - mem_read=1.
  - Lane select uses addr[1:0]: byte lane addr[1:0], halfword lane addr[1].
  - Sign- or zero-extend per funct3, register into load_data, go to DONE.
- READ:
  - mem_read=1; register mem_read_data as old word; go to WRITE.
- WRITE:
  - mem_write=1.
  - mem_write_data is store_data for SW.
  - For SB/SH it is the old word with the addressed byte/halfword lane replaced by store_data[7:0]/[15:0].
  - Go to DONE.
- DONE: done=1, then IDLE.
- Out of range (word index >= DEPTH_WORDS):
  - mem_read and mem_write are suppressed in every state.
  - A load returns load_data=0.
  - A store has no effect.
  - The sequence length is unchanged.
- mem_address is held at the registered word index from acceptance until IDLE.
- In IDLE, mem_read and mem_write are 0.

## Timing
- Request accepted at edge T (req_valid & req_ready).
- Load: LOAD in T+1, done in T+2 with load_data valid.
- SW: WRITE in T+1 (memory written at edge ending T+1), done in T+2.
- SB/SH: READ in T+1, WRITE in T+2, done in T+3.
- Illegal/rejected request: done in T+1.
- req_ready falls the cycle after acceptance and returns the cycle after done. Back-to-back requests are spaced by at least one IDLE cycle.
- Reset values:
  - State IDLE, so req_ready=1.
  - load_data=0, done=0, misaligned=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- rst forces mem_read and mem_write to 0 in the same cycle, combinationally. Reset mid-RMW therefore never writes a partial word; the state is IDLE on the next cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Halfword access with addr[0]=1 or word access with addr[1:0]!=0 goes IDLE→DONE.
  - done=1 and misaligned=1 in that cycle.
  - No memory strobe; load_data unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - Low address bits are forced to alignment (halfword clears addr[0], word clears addr[1:0]).
  - The access proceeds normally; misaligned is tied 0.

## Test plan
- Reset, then mem[3]=0x8081_F2A4, LB addr=0x0F → done at T+2, load_data=0xFFFF_FF80; LBU same → 0x0000_0080.
- mem[2]=0x1122_3344, SB addr=0x09 store_data=0xAB → mem_read in T+1, mem_write in T+2, mem_write_data=0x1122_AB44, done at T+3.
- SH addr=0x0A store_data=0xBEEF on mem[2]=0x1122_3344 → mem[2]=0xBEEF_3344; following LH addr=0x0A → 0xFFFF_BEEF.
- LW addr=0x06: with macro → done and misaligned at T+1, no mem_read; without macro → reads mem[1], misaligned=0.
- SW addr=0x80 (word 32, DEPTH_WORDS=32) → no mem_write, done at T+2; LW addr=0x80 → load_data=0.
- SB accepted, rst asserted during WRITE cycle → mem_write=0 that cycle, memory unchanged, req_ready=1 next cycle, all outputs at reset values.
